// File: rtl/dac_sample_scheduler.sv
// DDS-style sample pacer for the dual-channel DAC serializer: a rate timer, a phase accumulator and a go/ready handshake FSM.
// Optional handshake watchdog enabled by defining DAC_SCHED_TIMEOUT_EN.
module dac_sample_scheduler #(
    parameter int LUT_SIZE    = 128,
    parameter int ACC_W       = 16,
    parameter int DIV_W       = 16,
    parameter int ROM_LAT     = 1,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        phase_clr,
    input  logic [DIV_W-1:0]            rate_div,
    input  logic [ACC_W-1:0]            phase_inc,
    input  logic [$clog2(LUT_SIZE)-1:0] ch2_offset,
    output logic [$clog2(LUT_SIZE)-1:0] addr1,
    output logic [$clog2(LUT_SIZE)-1:0] addr2,
    output logic                        go,
    input  logic                        ready,
    output logic                        busy,
    output logic [7:0]                  overrun_cnt,
    output logic                        timeout_err
);

    localparam int ADDR_W  = $clog2(LUT_SIZE);
    // One counter times both the ROM latency and the watchdog, so it is sized for the larger.
    localparam int CNT_MAX = (TIMEOUT_CYC > ROM_LAT) ? TIMEOUT_CYC : ROM_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(ROM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DIV_W-1:0]  timer_q, timer_d;
    logic [ACC_W-1:0]  acc_q;
    logic [ADDR_W-1:0] addr1_q, addr2_q;
    logic              go_q, busy_q;
    logic [7:0]        ovr_q;
    logic              tick, drop;
    logic [ADDR_W-1:0] acc_addr;

    assign tick     = enable && (timer_q == rate_div);
    assign drop     = tick && !((state_q == S_IDLE) && ready);
    assign acc_addr = acc_q[ACC_W-1 -: ADDR_W];

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        timer_d = timer_q + 1'b1;
        if (!enable || tick) begin
            timer_d = '0;
        end
    end

`ifdef DAC_SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic timeout_q;
    logic xfer_done;
    assign xfer_done = (state_q == S_WAIT_DONE) && ready;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            timer_q <= '0;
            acc_q   <= '0;
            addr1_q <= '0;
            addr2_q <= '0;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= '0;
`ifdef DAC_SCHED_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            timer_q <= timer_d;
            go_q    <= 1'b0;
            if (drop && (ovr_q != 8'hFF)) begin
                ovr_q <= ovr_q + 8'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (phase_clr) begin
                        acc_q <= '0;
                    end
                    if (tick && ready) begin
                        addr1_q <= acc_addr;
                        addr2_q <= acc_addr + ch2_offset;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (cnt_q == LAT_LAST) begin
                        go_q    <= 1'b1;
                        state_q <= S_FIRE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_FIRE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (!ready) begin
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (ready) begin
                        // A clear coinciding with the update takes priority over the step.
                        acc_q   <= phase_clr ? '0 : acc_q + phase_inc;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
`ifdef DAC_SCHED_TIMEOUT_EN
            if ((state_q == S_WAIT_ACK || state_q == S_WAIT_DONE) && !xfer_done) begin
                if (cnt_q == WD_LAST) begin
                    busy_q    <= 1'b0;
                    timeout_q <= 1'b1;
                    state_q   <= S_IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
`endif
        end
    end

    assign addr1       = addr1_q;
    assign addr2       = addr2_q;
    assign go          = go_q;
    assign busy        = busy_q;
    assign overrun_cnt = ovr_q;
`ifdef DAC_SCHED_TIMEOUT_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Scoreboard bench for dac_sample_scheduler: stimulus queues expected go transactions, a negedge monitor checks them.
module tb_dac_sample_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        phase_clr = 1'b0;
    logic [15:0] rate_div = '0;
    logic [15:0] phase_inc = '0;
    logic [6:0]  ch2_offset = '0;
    logic [6:0]  addr1, addr2;
    logic        go;
    logic        ready = 1'b1;
    logic        busy;
    logic [7:0]  overrun_cnt;
    logic        timeout_err;

    dac_sample_scheduler #(
        .LUT_SIZE(128), .ACC_W(16), .DIV_W(16), .ROM_LAT(1), .TIMEOUT_CYC(64)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .phase_clr(phase_clr),
        .rate_div(rate_div), .phase_inc(phase_inc), .ch2_offset(ch2_offset),
        .addr1(addr1), .addr2(addr2), .go(go), .ready(ready), .busy(busy),
        .overrun_cnt(overrun_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] a1;
        logic [6:0] a2;
        int         gap;   // expected cycles since last go / enable; 0 = don't care
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_go_cyc = 0;
    int   go_seen = 0;
    bit   sb_en = 1'b1;
    logic prev_go = 1'b0;

    int   ser_len = 3;
    int   ser_cnt = 0;
    bit   ser_abort = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Serializer model: drops ready after go, raises it again ser_len negedges later.
    always @(negedge clk) begin
        if (go) begin
            ready   = 1'b0;
            ser_cnt = ser_len;
        end else if (ser_cnt > 0) begin
            ser_cnt = ser_abort ? 0 : ser_cnt - 1;
            if (ser_cnt == 0) ready = 1'b1;
        end
    end

    // Monitor: pops one expectation per go pulse.
    always @(negedge clk) begin
        if (!rst && go) begin
            check("go_width", {31'd0, prev_go}, 32'd0);
            if (sb_en) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_go: go with empty scoreboard, addr1=%0d addr2=%0d", addr1, addr2);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("addr1", {25'd0, addr1}, {25'd0, mon_e.a1});
                    check("addr2", {25'd0, addr2}, {25'd0, mon_e.a2});
                    if (mon_e.gap != 0) check("go_gap", cyc - last_go_cyc, mon_e.gap);
                end
            end
            last_go_cyc = cyc;
            go_seen++;
        end
        prev_go = go;
    end

    task automatic push(input int a1, input int a2, input int gap);
        exp_t e;
        e.a1  = 7'(a1);
        e.a2  = 7'(a2);
        e.gap = gap;
        sb_q.push_back(e);
    endtask

    task automatic wait_go(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!go && n < budget);
        if (!go) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_go: no go within %0d cycles", budget);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        if (busy) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles", budget);
        end
    endtask

    task automatic start(input int rd, input int inc, input int len);
        rate_div    = 16'(rd);
        phase_inc   = 16'(inc);
        ch2_offset  = 7'd64;
        ser_len     = len;
        enable      = 1'b1;
        last_go_cyc = cyc;
    endtask

    task automatic finish_burst();
        enable = 1'b0;
        wait_idle(100);
        check("sb_empty", sb_q.size(), 0);
    endtask

    task automatic do_reset();
        enable = 1'b0;
        phase_clr = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int base;
        repeat (2) @(negedge clk);
        check("rst_addr1", {25'd0, addr1}, 0);
        check("rst_addr2", {25'd0, addr2}, 0);
        check("rst_go", {31'd0, go}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_overrun", {24'd0, overrun_cnt}, 0);
        check("rst_timeout", {31'd0, timeout_err}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Steady state: tick every 10 cycles, addresses step by one.
        start(9, 16'h0200, 3);
        push(0, 64, 11);
        for (int i = 1; i < 5; i++) push(i, 64 + i, 10);
        repeat (5) wait_go(30);
        finish_burst();
        check("steady_overrun", {24'd0, overrun_cnt}, 0);

        // phase_clr in IDLE restarts the accumulator at zero.
        phase_clr = 1'b1;
        @(negedge clk);
        phase_clr = 1'b0;
        start(9, 16'h0200, 3);
        push(0, 64, 11);
        wait_go(30);
        finish_burst();

        // Wrap: one 0xFE00 step, then 0x0200 steps across the top of the LUT.
        do_reset();
        start(9, 16'hFE00, 3);
        push(0, 64, 11);
        push(127, 63, 10);
        push(0, 64, 10);
        push(1, 65, 10);
        wait_go(30);
        wait_idle(30);
        phase_inc = 16'h0200;
        repeat (3) wait_go(30);
        finish_burst();

        // Overrun: tick every 3 cycles against a 20-cycle serializer drops 7 ticks per transfer.
        do_reset();
        start(2, 16'h0200, 20);
        push(0, 64, 4);
        push(1, 65, 24);
        push(2, 66, 24);
        wait_go(30);
        wait_go(40);
        check("overrun_7", {24'd0, overrun_cnt}, 7);
        wait_go(40);
        check("overrun_14", {24'd0, overrun_cnt}, 14);
        @(negedge clk);
        sb_en = 1'b0;
        repeat (1150) @(negedge clk);
        check("overrun_sat", {24'd0, overrun_cnt}, 255);
        enable = 1'b0;
        wait_idle(100);
        sb_en = 1'b1;
        check("sb_empty_ovr", sb_q.size(), 0);

        // enable dropped during WAIT_DONE: transfer completes once, then nothing.
        do_reset();
        start(9, 16'h0200, 3);
        push(0, 64, 11);
        wait_go(30);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        check("dis_busy_mid", {31'd0, busy}, 1);
        base = go_seen;
        repeat (30) @(negedge clk);
        check("dis_no_go", go_seen - base, 0);
        check("dis_busy_end", {31'd0, busy}, 0);
        start(9, 16'h0200, 3);
        push(1, 65, 11);
        wait_go(30);
        finish_burst();

        // Reset pulse during WAIT_ACK clears outputs immediately; restart begins at addr 0.
        do_reset();
        start(0, 16'h0200, 3);
        push(0, 64, 2);
        push(1, 65, 6);
        push(2, 66, 6);
        repeat (3) wait_go(20);
        @(negedge clk);
        check("pre_rst_overrun", {24'd0, overrun_cnt}, 12);
        check("pre_rst_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        #1;
        check("rst5_go", {31'd0, go}, 0);
        check("rst5_addr1", {25'd0, addr1}, 0);
        check("rst5_addr2", {25'd0, addr2}, 0);
        check("rst5_busy", {31'd0, busy}, 0);
        check("rst5_overrun", {24'd0, overrun_cnt}, 0);
        @(negedge clk);
        rst = 1'b0;
        push(0, 64, 0);
        wait_go(30);
        finish_burst();

        // Serializer stuck low after go: watchdog aborts when built in, otherwise the FSM waits.
        do_reset();
        start(9, 16'h0200, 1000000);
        push(0, 64, 11);
        wait_go(30);
        enable = 1'b0;
        repeat (64) @(negedge clk);
        check("stuck_busy_64", {31'd0, busy}, 1);
        @(negedge clk);
`ifdef DAC_SCHED_TIMEOUT_EN
        check("wd_busy", {31'd0, busy}, 0);
        check("wd_err", {31'd0, timeout_err}, 1);
`else
        check("hang_busy", {31'd0, busy}, 1);
        check("hang_err", {31'd0, timeout_err}, 0);
`endif
        ser_abort = 1'b1;
        repeat (3) @(negedge clk);
        ser_abort = 1'b0;
        wait_idle(20);
        start(9, 16'h0200, 3);
`ifdef DAC_SCHED_TIMEOUT_EN
        push(0, 64, 11);
`else
        push(1, 65, 11);
`endif
        wait_go(30);
        finish_burst();
`ifdef DAC_SCHED_TIMEOUT_EN
        check("wd_err_sticky", {31'd0, timeout_err}, 1);
`else
        check("err_tied0", {31'd0, timeout_err}, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
